mod_mul_seq: RTL and testbench

//  Sequential modular multiplier: result = (A * B) mod N, MSB-first double-and-add, one bit of B per clock.

---
 rtl/ecm_pkg.sv | 5 +
 rtl/mod_dbl_add_step.sv | 20 ++
 rtl/mod_mul_seq.sv | 73 +++++++
 tb/tb_mod_mul_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecm_pkg.sv
// ecm_pkg: shared widths and state encoding for the ECM arithmetic sequencers
package ecm_pkg;
   localparam int NUM_WIDTH_DEFAULT = 256;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_t;
endpackage

// File: rtl/mod_dbl_add_step.sv
// mod_dbl_add_step: one MSB-first double-and-add step of a modular multiply
module mod_dbl_add_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] r,
   input  logic [W-1:0] a,
   input  logic [W-1:0] n,
   input  logic         b,
   output logic [W-1:0] r_next
);
   logic [W:0] nx, d, dr, s;
   // double r, reduce, add a when the multiplier bit is set, reduce again
   always_comb begin
      nx     = {1'b0, n};
      d      = {r, 1'b0};
      dr     = d >= nx ? d - nx : d;
      s      = dr + (b ? {1'b0, a} : '0);
      r_next = s >= nx ? W'(s - nx) : s[W-1:0];
   end
endmodule

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: sequential (A*B) mod N, one multiplier bit per clock, valid/ready on both sides
module mod_mul_seq
   import ecm_pkg::*;
#(
   parameter int NUM_WIDTH = NUM_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NUM_WIDTH-1:0] A,
   input  logic [NUM_WIDTH-1:0] B,
   input  logic [NUM_WIDTH-1:0] N,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_WIDTH-1:0] result,
   output logic                 err
);
   localparam int CNT_W = $clog2(NUM_WIDTH);
   mm_state_t            state_q, state_d;
   logic [NUM_WIDTH-1:0] a_q, b_q, n_q, r_next;
   logic [CNT_W-1:0]     cnt;
   logic                 accept;
   assign accept = in_valid && in_ready;
   mod_dbl_add_step #(.W(NUM_WIDTH)) u_step (
      .r      (result),
      .a      (a_q),
      .n      (n_q),
      .b      (b_q[cnt]),
      .r_next (r_next)
   );
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // next state: accept, run exactly NUM_WIDTH steps, hold until the consumer takes the result
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = in_valid ? RUN : IDLE;
         RUN:     state_d = cnt == '0 ? DONE : RUN;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // handshake outputs decode the state only, so no input-to-output combinational path
   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
   end
   // operand latch on accept, one double-and-add step per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         result <= '0;
         cnt    <= '0;
         err    <= 1'b0;
      end else if (accept) begin
         a_q    <= A;
         b_q    <= B;
         n_q    <= N;
         result <= '0;
         cnt    <= CNT_W'(NUM_WIDTH - 1);
         err    <= (N == '0) || (A >= N);
      end else if (state_q == RUN) begin
         result <= r_next;
         cnt    <= cnt - CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_mod_mul_seq.sv
// tb_mod_mul_seq: scoreboard bench for the sequential modular multiplier at 8 and 256 bits
module tb_mod_mul_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       iv8 = 1'b0, or8 = 1'b0, ir8, ov8, err8;
   logic [7:0] a8 = '0, b8 = '0, n8 = '0, res8;
   logic         iv2 = 1'b0, or2 = 1'b0, ir2, ov2, err2;
   logic [255:0] a2 = '0, b2 = '0, n2 = '0, res2;

   typedef struct {logic [255:0] res; logic err;} exp_t;
   exp_t sb[$];
   int n_checks = 0;
   int n_fail = 0;

   mod_mul_seq #(.NUM_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .N(n8),
      .out_valid(ov8), .out_ready(or8), .result(res8), .err(err8));
   mod_mul_seq dut256 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .N(n2),
      .out_valid(ov2), .out_ready(or2), .result(res2), .err(err2));

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
      exp_t e;
      logic [15:0] p;
      @(negedge clk);
      a8 = a; b8 = b; n8 = n; iv8 = 1'b1;
      p = 16'(a) * 16'(b);
      e.err = (n == 8'd0) || (a >= n);
      e.res = (n == 8'd0) ? '0 : 256'(p % {8'd0, n});
      sb.push_back(e);
      @(negedge clk);
      iv8 = 1'b0;
   endtask

   task automatic wait8(output int lat, output logic ir_low);
      lat = -1;
      ir_low = 1'b1;
      for (int j = 0; j < 20; j++) begin
         if (ov8) begin
            lat = j;
            break;
         end
         if (ir8) ir_low = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic handoff8();
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks += 5;
      if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ir8); end
      if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
      if (res8 !== 8'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", res8); end
      if (err8 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err8); end
      if (ir2 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_256: got %b expected 1", ir2); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      logic irl;
      exp_t e;
      start8(8'd5, 8'd7, 8'd11);
      wait8(lat, irl);
      e = sb.pop_front();
      n_checks += 4;
      if (lat != 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
      if (irl !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_low: in_ready seen high during RUN"); end
      if (res8 !== e.res[7:0]) begin n_fail++; $display("FAIL basic_result: got %0d expected %0d", res8, e.res[7:0]); end
      if (err8 !== e.err) begin n_fail++; $display("FAIL basic_err: got %b expected %b", err8, e.err); end
      handoff8();
      n_checks += 3;
      if (ov8 !== 1'b0) begin n_fail++; $display("FAIL basic_handoff_valid: got %b expected 0", ov8); end
      if (ir8 !== 1'b1) begin n_fail++; $display("FAIL basic_handoff_ready: got %b expected 1", ir8); end
      if (res8 !== e.res[7:0]) begin n_fail++; $display("FAIL basic_result_kept: got %0d expected %0d", res8, e.res[7:0]); end
   endtask

   task automatic test_patterns();
      logic [7:0] ta[6] = '{8'd254, 8'd0, 8'd9, 8'd200, 8'd1, 8'd100};
      logic [7:0] tb[6] = '{8'd254, 8'd200, 8'd0, 8'd255, 8'd1, 8'd3};
      logic [7:0] tn[6] = '{8'd255, 8'd13, 8'd11, 8'd251, 8'd2, 8'd128};
      int lat;
      logic irl;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         start8(ta[i], tb[i], tn[i]);
         wait8(lat, irl);
         e = sb.pop_front();
         n_checks += 3;
         if (lat != 8) begin n_fail++; $display("FAIL pattern%0d_latency: got %0d expected 8", i, lat); end
         if (res8 !== e.res[7:0]) begin n_fail++; $display("FAIL pattern%0d_result: got %0d expected %0d", i, res8, e.res[7:0]); end
         if (err8 !== e.err) begin n_fail++; $display("FAIL pattern%0d_err: got %b expected %b", i, err8, e.err); end
         handoff8();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic irl;
      exp_t e;
      start8(8'd6, 8'd9, 8'd13);
      wait8(lat, irl);
      e = sb.pop_front();
      for (int k = 0; k < 6; k++) begin
         n_checks += 3;
         if (ov8 !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid: got %b expected 1", k, ov8); end
         if (ir8 !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready: got %b expected 0", k, ir8); end
         if (res8 !== e.res[7:0]) begin n_fail++; $display("FAIL bp%0d_result: got %0d expected %0d", k, res8, e.res[7:0]); end
         if (k == 5) break;
         a8 = 8'd1; b8 = 8'd1; n8 = 8'd3; iv8 = 1'b1;
         @(negedge clk);
      end
      iv8 = 1'b0;
      handoff8();
      n_checks += 3;
      if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_handoff_valid: got %b expected 0", ov8); end
      if (ir8 !== 1'b1) begin n_fail++; $display("FAIL bp_handoff_ready: got %b expected 1", ir8); end
      if (res8 !== e.res[7:0]) begin n_fail++; $display("FAIL bp_result_kept: got %0d expected %0d", res8, e.res[7:0]); end
   endtask

   task automatic test_err();
      logic [7:0] ta[2] = '{8'd3, 8'd12};
      logic [7:0] tb[2] = '{8'd4, 8'd5};
      logic [7:0] tn[2] = '{8'd0, 8'd11};
      int lat;
      logic irl;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         start8(ta[i], tb[i], tn[i]);
         wait8(lat, irl);
         e = sb.pop_front();
         n_checks += 2;
         if (lat != 8) begin n_fail++; $display("FAIL err%0d_latency: got %0d expected 8", i, lat); end
         if (err8 !== e.err) begin n_fail++; $display("FAIL err%0d_flag: got %b expected %b", i, err8, e.err); end
         handoff8();
         n_checks++;
         if (ir8 !== 1'b1) begin n_fail++; $display("FAIL err%0d_back_to_idle: got %b expected 1", i, ir8); end
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      logic irl;
      exp_t e;
      start8(8'd7, 8'd255, 8'd11);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      e = sb.pop_front();
      n_checks += 4;
      if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", ov8); end
      if (ir8 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", ir8); end
      if (res8 !== 8'd0) begin n_fail++; $display("FAIL midrst_result: got %0d expected 0", res8); end
      if (err8 !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", err8); end
      @(negedge clk);
      rst_n = 1'b1;
      start8(8'd4, 8'd10, 8'd11);
      wait8(lat, irl);
      e = sb.pop_front();
      n_checks += 2;
      if (lat != 8) begin n_fail++; $display("FAIL postrst_latency: got %0d expected 8", lat); end
      if (res8 !== e.res[7:0]) begin n_fail++; $display("FAIL postrst_result: got %0d expected %0d", res8, e.res[7:0]); end
      handoff8();
   endtask

   task automatic test_random256();
      exp_t e;
      logic [511:0] p;
      logic done;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         n_checks++;
         if (ir2 !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_in_ready: got %b expected 1", i, ir2); end
         n2 = rnd256();
         n2[0] = i[0];
         if (n2 < 256'd2) n2 = 256'd7;
         a2 = rnd256() % n2;
         b2 = rnd256();
         if (i == 0) b2 = '0;
         iv2 = 1'b1;
         p = {256'd0, a2} * {256'd0, b2};
         e.res = 256'(p % {256'd0, n2});
         e.err = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         iv2 = 1'b0;
         done = 1'b0;
         for (int c = 0; c < 400 && !done; c++) begin
            or2 = 1'($urandom_range(0, 1));
            if (ov2 && or2) begin
               e = sb.pop_front();
               n_checks += 2;
               if (res2 !== e.res) begin n_fail++; $display("FAIL rnd%0d_result: got %h expected %h", i, res2, e.res); end
               if (err2 !== e.err) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", i, err2, e.err); end
               done = 1'b1;
            end
            @(negedge clk);
         end
         or2 = 1'b0;
         if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd%0d_timeout: out_valid never handed off", i);
            e = sb.pop_front();
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_backpressure();
      test_err();
      test_reset_midrun();
      test_random256();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
